// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage buffer.
// Holds the default bundle widths, field positions inside the control and data
// bundles, the buffer state encoding and the all-zero (NOP) control value.
package pipe_pkg;

    // Default widths for the ID/EX boundary.
    localparam int CTRL_W_DEF = 10;
    localparam int DATA_W_DEF = 138;
    localparam int CNT_W_DEF  = 16;

    // Control bundle layout, MSB first:
    // MemToReg, MemToWrite, AluOp[2:0], RegWrite, RegDst, Branch, MemRead, Alusrc
    localparam int CTRL_ALUSRC_BIT     = 0;
    localparam int CTRL_MEMREAD_BIT    = 1;
    localparam int CTRL_BRANCH_BIT     = 2;
    localparam int CTRL_REGDST_BIT     = 3;
    localparam int CTRL_REGWRITE_BIT   = 4;
    localparam int CTRL_ALUOP_LSB      = 5;
    localparam int CTRL_ALUOP_W        = 3;
    localparam int CTRL_MEMTOWRITE_BIT = 8;
    localparam int CTRL_MEMTOREG_BIT   = 9;

    // Payload layout, MSB first:
    // Read_D1, Read_D2, Sign_Extend, PC_adder (32b each), Ins_2016, Ins_1511 (5b each)
    localparam int DATA_INS1511_LSB  = 0;
    localparam int DATA_INS2016_LSB  = 5;
    localparam int DATA_PC_ADDER_LSB = 10;
    localparam int DATA_SIGN_EXT_LSB = 42;
    localparam int DATA_READ_D2_LSB  = 74;
    localparam int DATA_READ_D1_LSB  = 106;

    // Occupancy of the two-slot buffer (main slot drives the outputs).
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    // Control value presented on bubbles: no register write, no store, no branch.
    localparam logic [CTRL_W_DEF-1:0] CTRL_NOP = '0;

    // True when a default-layout control word has an architectural side effect.
    function automatic logic ctrl_has_side_effect(input logic [CTRL_W_DEF-1:0] c);
        return c[CTRL_REGWRITE_BIT] | c[CTRL_MEMTOWRITE_BIT] | c[CTRL_BRANCH_BIT];
    endfunction

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating event counter: counts cycles with inc=1, sticks at all-ones.
// Latency: count visible the cycle after the counted event.
// Backpressure: none; a plain event sink.
// Ports: clk, rst_n (async active-low), inc (count this cycle), cnt (current value).
module pipe_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline register (ID/EX, EX/MEM, MEM/WB) with a 2-entry skid buffer.
// Latency: one cycle from input accept to output valid; sustains 1 entry/cycle.
// Backpressure: in_ready is registered and drops only when both slots are full.
//
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   in_valid/in_ready     upstream handshake; in_ctrl/in_data upstream bundle
//   flush                 kills held and incoming entries, output becomes a bubble
//   out_valid/out_ready   downstream handshake; out_ctrl/out_data registered bundle
//   stall_cnt, bubble_cnt, flush_cnt
//                         saturating perf counters, only with PIPE_STAGE_PERF_EN
//
// Build option: define PIPE_STAGE_PERF_EN to add the perf counters.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,

    input  logic              flush,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    localparam logic [CTRL_W-1:0] NOP = CTRL_W'(CTRL_NOP);

    state_e             state;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [CTRL_W-1:0]  main_ctrl;
    logic [DATA_W-1:0]  main_data;
    logic [CTRL_W-1:0]  skid_ctrl;
    logic [DATA_W-1:0]  skid_data;

    logic               in_xfer;
    logic               out_xfer;

    assign in_xfer  = in_valid & in_ready_q;
    assign out_xfer = out_valid_q & out_ready;

    // in_ready and out_valid are kept as registers updated alongside the state,
    // so neither depends combinationally on the downstream ready.
    // main_ctrl is cleared on every transition into EMPTY, which keeps the
    // bubble-is-NOP property purely registered (no output mux on valid).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            main_ctrl   <= NOP;
            main_data   <= '0;
            skid_ctrl   <= NOP;
            skid_data   <= '0;
        end else if (flush) begin
            // Held entries and any same-cycle input are dropped; data is left
            // as-is since it is meaningless without valid.
            state       <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            main_ctrl   <= NOP;
        end else begin
            unique case (state)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        state       <= ST_ONE;
                        out_valid_q <= 1'b1;
                        main_ctrl   <= in_ctrl;
                        main_data   <= in_data;
                    end
                end
                ST_ONE: begin
                    if (in_xfer && !out_xfer) begin
                        // Downstream stalled this cycle: park the newcomer.
                        state      <= ST_TWO;
                        in_ready_q <= 1'b0;
                        skid_ctrl  <= in_ctrl;
                        skid_data  <= in_data;
                    end else if (in_xfer && out_xfer) begin
                        main_ctrl <= in_ctrl;
                        main_data <= in_data;
                    end else if (out_xfer) begin
                        state       <= ST_EMPTY;
                        out_valid_q <= 1'b0;
                        main_ctrl   <= NOP;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so no capture can coincide.
                    if (out_xfer) begin
                        state      <= ST_ONE;
                        in_ready_q <= 1'b1;
                        main_ctrl  <= skid_ctrl;
                        main_data  <= skid_data;
                    end
                end
                default: begin
                    state       <= ST_EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    main_ctrl   <= NOP;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_ctrl  = main_ctrl;
    assign out_data  = main_data;

`ifdef PIPE_STAGE_PERF_EN
    pipe_sat_cnt #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (out_valid_q & ~out_ready),
        .cnt   (stall_cnt)
    );

    pipe_sat_cnt #(.W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (~out_valid_q),
        .cnt   (bubble_cnt)
    );

    pipe_sat_cnt #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush),
        .cnt   (flush_cnt)
    );
`endif

endmodule
